// File: rtl/esd_host_agent_pkg.sv
// Shared definitions for the emergency-shutdown host agent and the controller's debug view.
// Holds the agent state encoding and the state_o width.
package esd_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_TRIPPED = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_ACK     = 3'd4,
        ST_VERIFY  = 3'd5,
        ST_LOCKOUT = 3'd6
    } agent_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/esd_host_agent_if.sv
// Signal bundle between the host agent (master) and its host/controller side (slave).
interface esd_host_agent_if;
    import esd_pkg::*;

    logic               enable_i;
    logic               fault_i;
    logic               shutdown_i;
    logic               estop_clear_i;
    logic               wdg_kick_o;
    logic               ack_n_o;
    logic               lockout_o;
    logic [STATE_W-1:0] state_o;

    modport master (
        input  enable_i, fault_i, shutdown_i, estop_clear_i,
        output wdg_kick_o, ack_n_o, lockout_o, state_o
    );

    modport slave (
        output enable_i, fault_i, shutdown_i, estop_clear_i,
        input  wdg_kick_o, ack_n_o, lockout_o, state_o
    );

endinterface

// File: rtl/esd_host_agent_sync2.sv
// Generic two-flop synchronizer for a single asynchronous level input.
module esd_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= RST_VAL;
            sync_reg <= RST_VAL;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/esd_host_agent.sv
// Host agent for the emergency-shutdown controller: periodic watchdog kick plus the
// post-trip recovery handshake (settle, ack pulse, verify) with bounded retries.
module esd_host_agent
    import esd_pkg::*;
#(
    parameter int KICK_PERIOD    = 1000,
    parameter int KICK_WIDTH     = 4,
    parameter int SETTLE_CYCLES  = 256,
    parameter int ACK_WIDTH      = 16,
    parameter int VERIFY_TIMEOUT = 1024,
    parameter int MAX_ACK_TRIES  = 3
) (
    input logic               clk,
    input logic               rst_n,
    esd_host_agent_if.master  bus
);

    localparam int WIN_W   = $clog2(KICK_PERIOD);
    localparam int PH_W    = $clog2(max3(SETTLE_CYCLES, ACK_WIDTH, VERIFY_TIMEOUT)) + 1;
    localparam int RETRY_W = $clog2(MAX_ACK_TRIES) + 1;

    localparam logic [WIN_W-1:0]   WIN_LAST    = WIN_W'(KICK_PERIOD - 1);
    localparam logic [WIN_W-1:0]   KICK_LIMIT  = WIN_W'(KICK_WIDTH);
    localparam logic [PH_W-1:0]    SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
    localparam logic [PH_W-1:0]    ACK_LAST    = PH_W'(ACK_WIDTH - 1);
    localparam logic [PH_W-1:0]    VERIFY_LAST = PH_W'(VERIFY_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_ACK_TRIES);

    logic shut_s;
    logic clr_s;

    esd_sync2 #(.RST_VAL(1'b0)) u_sync_shut (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.shutdown_i),
        .q     (shut_s)
    );

    esd_sync2 #(.RST_VAL(1'b0)) u_sync_clr (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.estop_clear_i),
        .q     (clr_s)
    );

    agent_state_e       state_reg;
    logic [WIN_W-1:0]   win_reg;
    logic [PH_W-1:0]    phase_reg;
    logic [RETRY_W-1:0] retry_reg;
    logic               kick_reg;
    logic               ack_n_reg;
    logic               lockout_reg;

    logic [WIN_W-1:0]   win_next;
    logic [RETRY_W-1:0] retry_next;

    // win_reg is the window position of the cycle currently on the outputs.
    assign win_next   = (win_reg == WIN_LAST) ? '0 : win_reg + 1'b1;
    assign retry_next = retry_reg + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            win_reg     <= '0;
            phase_reg   <= '0;
            retry_reg   <= '0;
            kick_reg    <= 1'b0;
            ack_n_reg   <= 1'b1;
            lockout_reg <= 1'b0;
        end else if (!bus.enable_i) begin
            state_reg   <= ST_IDLE;
            win_reg     <= '0;
            phase_reg   <= '0;
            retry_reg   <= '0;
            kick_reg    <= 1'b0;
            ack_n_reg   <= 1'b1;
            lockout_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_reg <= ST_RUN;
                    win_reg   <= '0;
                    kick_reg  <= !bus.fault_i;
                end
                ST_RUN: begin
                    if (shut_s) begin
                        state_reg <= ST_TRIPPED;
                        kick_reg  <= 1'b0;
                    end else begin
                        win_reg  <= win_next;
                        kick_reg <= (win_next < KICK_LIMIT) && !bus.fault_i;
                    end
                end
                ST_TRIPPED: begin
                    if (clr_s && !bus.fault_i) begin
                        state_reg <= ST_SETTLE;
                        phase_reg <= '0;
                    end
                end
                ST_SETTLE: begin
                    // Losing the clear or a host fault restarts the whole settle.
                    if (!clr_s || bus.fault_i) begin
                        state_reg <= ST_TRIPPED;
                        phase_reg <= '0;
                    end else if (phase_reg == SETTLE_LAST) begin
                        state_reg <= ST_ACK;
                        phase_reg <= '0;
                        ack_n_reg <= 1'b0;
                    end else begin
                        phase_reg <= phase_reg + 1'b1;
                    end
                end
                ST_ACK: begin
                    if (phase_reg == ACK_LAST) begin
                        state_reg <= ST_VERIFY;
                        phase_reg <= '0;
                        ack_n_reg <= 1'b1;
                        win_reg   <= '0;
                        kick_reg  <= !bus.fault_i;
                    end else begin
                        phase_reg <= phase_reg + 1'b1;
                    end
                end
                ST_VERIFY: begin
                    if (!shut_s) begin
                        state_reg <= ST_RUN;
                        phase_reg <= '0;
                        retry_reg <= '0;
                        win_reg   <= '0;
                        kick_reg  <= !bus.fault_i;
                    end else if (phase_reg == VERIFY_LAST) begin
                        phase_reg <= '0;
                        win_reg   <= '0;
                        kick_reg  <= 1'b0;
                        retry_reg <= retry_next;
                        if (retry_next == RETRY_MAX) begin
                            state_reg   <= ST_LOCKOUT;
                            lockout_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_SETTLE;
                        end
                    end else begin
                        phase_reg <= phase_reg + 1'b1;
                        win_reg   <= win_next;
                        kick_reg  <= (win_next < KICK_LIMIT) && !bus.fault_i;
                    end
                end
                ST_LOCKOUT: begin
                    state_reg <= ST_LOCKOUT;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.state_o    = state_reg;
    assign bus.wdg_kick_o = kick_reg;
    assign bus.ack_n_o    = ack_n_reg;
    assign bus.lockout_o  = lockout_reg;

endmodule

// File: tb/tb_esd_host_agent.sv
// Directed bench for esd_host_agent with small parameters; expected sequences are hand-derived.
module tb_esd_host_agent;

    localparam int S_IDLE = 0, S_RUN = 1, S_TRIP = 2, S_SETTLE = 3;
    localparam int S_ACK = 4, S_VERIFY = 5, S_LOCK = 6;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    esd_host_agent_if bus ();

    esd_host_agent #(
        .KICK_PERIOD    (8),
        .KICK_WIDTH     (2),
        .SETTLE_CYCLES  (4),
        .ACK_WIDTH      (3),
        .VERIFY_TIMEOUT (10),
        .MAX_ACK_TRIES  (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Waits len cycles expecting state st each cycle; kick follows an 8-cycle window
    // starting at position kstart in RUN/VERIFY (kstart < 0 skips the kick check).
    task automatic seg(input string tag, input int st, input int len, input int kstart);
        logic exp_kick;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            chk($sformatf("%s_state", tag), 8'(bus.state_o), 8'(st));
            chk($sformatf("%s_ack_n", tag), 8'(bus.ack_n_o), (st == S_ACK) ? 8'd0 : 8'd1);
            chk($sformatf("%s_lockout", tag), 8'(bus.lockout_o), (st == S_LOCK) ? 8'd1 : 8'd0);
            if (kstart >= 0) begin
                exp_kick = (st == S_RUN || st == S_VERIFY) && (((kstart + k) % 8) < 2);
                chk($sformatf("%s_kick", tag), 8'(bus.wdg_kick_o), 8'(exp_kick));
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk($sformatf("%s_state", tag), 8'(bus.state_o), 8'd0);
        chk($sformatf("%s_kick", tag), 8'(bus.wdg_kick_o), 8'd0);
        chk($sformatf("%s_ack_n", tag), 8'(bus.ack_n_o), 8'd1);
        chk($sformatf("%s_lockout", tag), 8'(bus.lockout_o), 8'd0);
    endtask

    initial begin
        int pos;
        int pulses;
        logic prev_kick;
        logic exp_kick;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.enable_i      = 1'b0;
        bus.fault_i       = 1'b0;
        bus.shutdown_i    = 1'b0;
        bus.estop_clear_i = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("idle");

        // Free-running kick: 40 cycles, 2-of-8 pulses, first kick one cycle after enable
        bus.enable_i = 1'b1;
        pos = -1;
        pulses = 0;
        prev_kick = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            pos = (pos + 1) % 8;
            if (i == 0) chk("t1_first_state", 8'(bus.state_o), 8'(S_RUN));
            chk("t1_kick", 8'(bus.wdg_kick_o), 8'(pos < 2));
            chk("t1_ack_n", 8'(bus.ack_n_o), 8'd1);
            if (bus.wdg_kick_o && !prev_kick) pulses++;
            prev_kick = bus.wdg_kick_o;
        end
        chk("t1_pulses", 8'(pulses), 8'd5);

        // Fault suppresses kicks for steps 10..30 without disturbing the window phase
        for (int j = 0; j < 40; j++) begin
            bus.fault_i = (j >= 10 && j <= 30);
            @(negedge clk);
            pos = (pos + 1) % 8;
            exp_kick = (pos < 2) && !bus.fault_i;
            chk("t2_kick", 8'(bus.wdg_kick_o), 8'(exp_kick));
        end
        bus.fault_i = 1'b0;
        chk("t2_state", 8'(bus.state_o), 8'(S_RUN));

        // Successful recovery: shutdown released during VERIFY cycle 2
        bus.shutdown_i    = 1'b1;
        bus.estop_clear_i = 1'b1;
        seg("t3_run", S_RUN, 2, -1);
        seg("t3_trip", S_TRIP, 1, 0);
        seg("t3_settle", S_SETTLE, 4, 0);
        seg("t3_ack", S_ACK, 3, 0);
        seg("t3_verify", S_VERIFY, 2, 0);
        bus.shutdown_i = 1'b0;
        seg("t3_verify_b", S_VERIFY, 2, 2);
        seg("t3_rerun", S_RUN, 1, 0);

        // E-stop clear drops at SETTLE cycle 2, settle restarts in full after it returns
        bus.shutdown_i = 1'b1;
        seg("t4_run", S_RUN, 2, -1);
        seg("t4_trip", S_TRIP, 1, 0);
        seg("t4_settle", S_SETTLE, 2, 0);
        bus.estop_clear_i = 1'b0;
        seg("t4_settle_b", S_SETTLE, 2, 0);
        seg("t4_retrip", S_TRIP, 2, 0);
        bus.estop_clear_i = 1'b1;
        seg("t4_retrip_b", S_TRIP, 2, 0);
        seg("t4_settle2", S_SETTLE, 4, 0);
        seg("t4_ack", S_ACK, 3, 0);
        seg("t4_verify", S_VERIFY, 1, 0);
        bus.shutdown_i = 1'b0;
        seg("t4_verify_b", S_VERIFY, 2, 1);
        seg("t4_rerun", S_RUN, 1, 0);

        // Shutdown stuck high: two failed acks, then lockout; disable clears it
        bus.shutdown_i = 1'b1;
        seg("t5_run", S_RUN, 2, -1);
        seg("t5_trip", S_TRIP, 1, 0);
        seg("t5_settle1", S_SETTLE, 4, 0);
        seg("t5_ack1", S_ACK, 3, 0);
        seg("t5_verify1", S_VERIFY, 10, 0);
        seg("t5_settle2", S_SETTLE, 4, 0);
        seg("t5_ack2", S_ACK, 3, 0);
        seg("t5_verify2", S_VERIFY, 10, 0);
        seg("t5_lock", S_LOCK, 3, 0);
        bus.enable_i = 1'b0;
        seg("t5_idle", S_IDLE, 2, 0);
        bus.shutdown_i = 1'b0;
        seg("t5_idle_b", S_IDLE, 3, 0);

        // Disable during ACK cycle 1 ends the pulse on the next cycle
        bus.enable_i = 1'b1;
        seg("t6_run", S_RUN, 8, 0);
        bus.shutdown_i = 1'b1;
        seg("t6_run_b", S_RUN, 2, 8);
        seg("t6_trip", S_TRIP, 1, 0);
        seg("t6_settle", S_SETTLE, 4, 0);
        seg("t6_ack", S_ACK, 1, 0);
        bus.enable_i = 1'b0;
        seg("t6_idle", S_IDLE, 2, 0);
        bus.shutdown_i = 1'b0;
        seg("t6_idle_b", S_IDLE, 3, 0);

        // Asynchronous reset mid-SETTLE takes effect immediately
        bus.enable_i = 1'b1;
        seg("t7_run", S_RUN, 1, 0);
        bus.shutdown_i = 1'b1;
        seg("t7_run_b", S_RUN, 2, 1);
        seg("t7_trip", S_TRIP, 1, 0);
        seg("t7_settle", S_SETTLE, 2, 0);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("t7_async_rst");
        bus.enable_i = 1'b0;
        @(negedge clk);
        chk_reset_outputs("t7_in_rst");
        rst_n = 1'b1;
        seg("t7_idle", S_IDLE, 2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
